mips_dmem_ctrl: RTL and testbench
=================================

# mips_dmem_ctrl

Parametrised, synthesizable data-memory controller for the MIPS pipeline MEM stage. Replaces the zero-latency behavioural data memory with a word-addressed array, a valid/ready request handshake, programmable wait states, alignment/range error reporting and optional byte-lane writes. It sits between the datapath's address/write-data outputs (ALU result, rt value) and its read-data input. The pipeline stalls on `busy`.

## Interface
- `DATA_W`, default 32: data width in bits; must be a multiple of 8.
- `DEPTH`, default 64: number of words; must be a power of two ≥ 2.
- `WAIT_CYCLES`, default 2: extra access latency, 0–15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset asserted). Release is synchronised externally.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the controller can accept a request this cycle.
- `req_we` in 1: 1 = store (sw), 0 = load (lw).
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in DATA_W: store data.
- `req_be` in DATA_W/8: byte-lane enables for stores.
- `resp_valid` out 1: one-cycle pulse; the access has completed.
- `resp_rdata` out DATA_W: load data, valid while `resp_valid`=1.
- `resp_err` out 1: the access was misaligned or out of range; valid while `resp_valid`=1.
- `busy` out 1: a request is in flight (state ≠ IDLE and ≠ RESP).

## Operation
- FSM states: IDLE, WAIT, RESP.
- Handshake: a request is accepted when `req_valid && req_ready`. `req_ready`=1 in IDLE and RESP, 0 in WAIT. On acceptance the controller registers we/addr/wdata/be and loads `cnt`=WAIT_CYCLES.
- Transitions:
  - IDLE to WAIT on acceptance.
  - In WAIT: if `cnt`≠0, decrement `cnt`; if `cnt`=0, perform the access and go to RESP.
  - RESP to WAIT if a new request is accepted in the RESP cycle; otherwise RESP to IDLE.
- Word index = `addr[$clog2(DEPTH)+1:2]`.
- Error conditions:
  - Misaligned: `addr[1:0]`≠0.
  - Out of range: any `addr` bit above `$clog2(DEPTH)+1` is set.
  - On either error: the store is suppressed (array unchanged), `resp_rdata`=0, `resp_err`=1.
- Load: `resp_rdata` is the registered array word. Store: `resp_rdata`=0.
- Stores update the array on the edge that enters RESP. A load issued immediately after a store to the same word returns the new value.
- Reset (any time, including mid-WAIT): state goes to IDLE, `cnt` to 0, and all outputs take their reset values. An in-flight store is dropped with no partial write. Array contents are not cleared.
- Inputs are ignored when no handshake occurs. Changing `req_*` while `req_ready`=0 has no effect.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0.
- Latency: acceptance at edge T gives `resp_valid`=1 during the cycle after edge T+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: response 1 cycle after acceptance.
  - WAIT_CYCLES=2 (default): response 3 cycles after acceptance.
- `resp_valid` is high for exactly one cycle per accepted request. There is no backpressure on the response.
- Back-to-back throughput (acceptance in RESP): one access per WAIT_CYCLES+2 cycles.
- `busy` is high from the edge after acceptance until the edge entering RESP.
- All outputs are registered. There are no combinational paths from `req_*` to any output.

## Configuration
- `DMEM_BYTE_EN_EN` defined:
  - Stores write only the lanes where `req_be[i]`=1. Lane i is bits [8i+7:8i].
  - `req_be`=0 performs a no-op store that still returns `resp_valid`.
- `DMEM_BYTE_EN_EN` undefined: the `req_be` port remains present but is ignored. Every store writes the full word.

## Test plan
- Reset: hold `reset`=0 for 2 cycles -> `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0.
- Store/load (WAIT_CYCLES=2):
  - Store 0x00000011 to address 0x4 -> `resp_valid` exactly 3 cycles after acceptance, `resp_err`=0.
  - Then load from 0x4 -> `resp_rdata`=0x00000011.
- Back-to-back: store 0xDEADBEEF to 0x8, with a load from 0x8 accepted in the store's RESP cycle -> load returns 0xDEADBEEF; responses are WAIT_CYCLES+2 cycles apart.
- Errors (DEPTH=64):
  - Load from 0x6 -> `resp_err`=1, `resp_rdata`=0.
  - Store to 0x100 -> `resp_err`=1, and word 0 is unchanged on a later read of 0x0.
- Byte enables: word 0xAABBCCDD at 0xC, then store 0x11223344 with `req_be`=4'b0101 ->
  - with `DMEM_BYTE_EN_EN` defined: read 0xAA22CC44;
  - without it: read 0x11223344.
- Reset mid-WAIT: store 0x55 to 0x10, drive `reset`=0 in the first WAIT cycle, then release -> no `resp_valid`, `req_ready`=1, and a read of 0x10 returns the old value.

Source files
------------

// File: rtl/mips_dmem_ctrl_if.sv
// Request/response bus between the MIPS MEM stage and the data-memory controller.
interface mips_dmem_ctrl_if #(
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [BE_W-1:0]   req_be;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );
endinterface

// File: rtl/mips_dmem_ctrl.sv
// Word-addressed data memory with valid/ready handshake, wait states and error reporting.
// Byte-lane stores are enabled by defining DMEM_BYTE_EN_EN.
module mips_dmem_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic             clk,
   input logic             reset,
   mips_dmem_ctrl_if.slave dmem
);
   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned BE_W    = DATA_W / 8;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TOP_LSB = IDX_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept_c;
   logic              access_c;
   logic              err_c;
   logic [IDX_W-1:0]  idx_c;
   logic [DATA_W-1:0] wmask_c;

   logic              ready_d;
   logic              valid_d;
   logic              busy_d;
   logic              err_d;
   logic [DATA_W-1:0] rdata_d;

   assign accept_c = dmem.req_valid && dmem.req_ready;
   assign access_c = (state == S_WAIT) && (cnt == '0);
   assign idx_c    = r_addr[IDX_W+1:2];
   assign err_c    = (r_addr[1:0] != 2'b00) || ((r_addr >> TOP_LSB) != 32'd0);

`ifdef DMEM_BYTE_EN_EN
   always_comb begin
      wmask_c = '0;
      for (int i = 0; i < int'(BE_W); i++) begin
         wmask_c[8*i +: 8] = {8{r_be[i]}};
      end
   end
`else
   logic unused_be_c;
   assign unused_be_c = ^r_be;
   assign wmask_c     = '1;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         S_IDLE: begin
            if (accept_c) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(WAIT_CYCLES);
            end
         end
         S_WAIT: begin
            if (cnt != '0) cnt_d   = cnt - CNT_W'(1);
            else           state_d = S_RESP;
         end
         S_RESP: begin
            if (accept_c) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(WAIT_CYCLES);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      ready_d = (state_d != S_WAIT);
      valid_d = (state_d == S_RESP);
      busy_d  = (state_d == S_WAIT);
      err_d   = 1'b0;
      rdata_d = '0;
      if (access_c) begin
         err_d = err_c;
         if (!r_we && !err_c) rdata_d = mem[idx_c];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dmem.req_ready  <= 1'b1;
         dmem.resp_valid <= 1'b0;
         dmem.busy       <= 1'b0;
         dmem.resp_err   <= 1'b0;
         dmem.resp_rdata <= '0;
      end else begin
         dmem.req_ready  <= ready_d;
         dmem.resp_valid <= valid_d;
         dmem.busy       <= busy_d;
         dmem.resp_err   <= err_d;
         dmem.resp_rdata <= rdata_d;
      end
   end

   // Request capture on handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (accept_c) begin
         r_we    <= dmem.req_we;
         r_addr  <= dmem.req_addr;
         r_wdata <= dmem.req_wdata;
         r_be    <= dmem.req_be;
      end
   end

   // Array is not reset; the write lands on the edge entering RESP
   always_ff @(posedge clk) begin
      if (access_c && r_we && !err_c) begin
         mem[idx_c] <= (mem[idx_c] & ~wmask_c) | (r_wdata & wmask_c);
      end
   end
endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Randomized self-checking bench for mips_dmem_ctrl against a word-array reference model.
module tb_mips_dmem_ctrl;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned WAITC  = 2;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [31:0] ref_mem [DEPTH];

   mips_dmem_ctrl_if #(.DATA_W(DATA_W)) dmem ();

   mips_dmem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk   (clk),
      .reset (reset),
      .dmem  (dmem.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic ref_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= DEPTH * 4);
   endfunction

   // Called at a negedge; returns at the negedge where resp_valid is seen.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int lat, output int t_resp);
      check("ready_idle", 32'(dmem.req_ready), 32'd1);
      dmem.req_valid = 1'b1;
      dmem.req_we    = we;
      dmem.req_addr  = addr;
      dmem.req_wdata = wdata;
      dmem.req_be    = be;
      @(posedge clk);
      @(negedge clk);
      dmem.req_valid = 1'b0;
      dmem.req_we    = 1'($urandom);
      dmem.req_addr  = $urandom;
      dmem.req_wdata = $urandom;
      dmem.req_be    = 4'($urandom);
      check("busy_wait", 32'(dmem.busy), 32'd1);
      check("ready_wait", 32'(dmem.req_ready), 32'd0);
      lat = 0;
      while (!dmem.resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!dmem.resp_valid) check("resp_timeout", 32'd0, 32'd1);
      rdata  = dmem.resp_rdata;
      err    = dmem.resp_err;
      t_resp = cyc;
      check("busy_resp", 32'(dmem.busy), 32'd0);
   endtask

   // Access plus comparison against the model; updates the model on good stores.
   task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output int t_resp);
      logic        e;
      logic        got_err;
      logic [31:0] exp_rd;
      int          lat;
      int          idx;
      e      = ref_err(addr);
      idx    = int'(addr[7:2]);
      exp_rd = (!we && !e) ? ref_mem[idx] : 32'd0;
      access(we, addr, wdata, be, rdata, got_err, lat, t_resp);
      check("latency", 32'(lat), 32'(WAITC + 1));
      check(we ? "st_err" : "ld_err", 32'(got_err), 32'(e));
      check(we ? "st_rdata" : "ld_rdata", rdata, exp_rd);
      if (we && !e) begin
`ifdef DMEM_BYTE_EN_EN
         for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[idx][8*i +: 8] = wdata[8*i +: 8];
`else
         ref_mem[idx] = wdata;
`endif
      end
   endtask

   task automatic gap();
      @(negedge clk);
      check("pulse_once", 32'(dmem.resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] old;
      logic [31:0] a;
      int          t1, t2, seen, r;

      reset          = 1'b0;
      dmem.req_valid = 1'b0;
      dmem.req_we    = 1'b0;
      dmem.req_addr  = '0;
      dmem.req_wdata = '0;
      dmem.req_be    = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(dmem.req_ready), 32'd1);
      check("rst_valid", 32'(dmem.resp_valid), 32'd0);
      check("rst_rdata", dmem.resp_rdata, 32'd0);
      check("rst_err", 32'(dmem.resp_err), 32'd0);
      check("rst_busy", 32'(dmem.busy), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Fill the array so every word is known to the model
      for (int i = 0; i < int'(DEPTH); i++) begin
         do_op(1'b1, 32'(i * 4), $urandom, 4'hF, rd, t1);
      end
      gap();

      do_op(1'b1, 32'h4, 32'h0000_0011, 4'hF, rd, t1);
      gap();
      do_op(1'b0, 32'h4, 32'h0, 4'hF, rd, t1);
      check("ld_0x4_const", rd, 32'h0000_0011);
      gap();

      do_op(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, rd, t1);
      do_op(1'b0, 32'h8, 32'h0, 4'hF, rd, t2);
      check("b2b_rdata", rd, 32'hDEAD_BEEF);
      check("b2b_spacing", 32'(t2 - t1), 32'(WAITC + 2));
      gap();

      do_op(1'b0, 32'h6, 32'h0, 4'hF, rd, t1);
      gap();
      old = ref_mem[0];
      do_op(1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, rd, t1);
      gap();
      do_op(1'b0, 32'h0, 32'h0, 4'hF, rd, t1);
      check("oor_word0", rd, old);
      gap();

      do_op(1'b1, 32'hC, 32'hAABB_CCDD, 4'hF, rd, t1);
      gap();
      do_op(1'b1, 32'hC, 32'h1122_3344, 4'b0101, rd, t1);
      gap();
      do_op(1'b0, 32'hC, 32'h0, 4'hF, rd, t1);
`ifdef DMEM_BYTE_EN_EN
      check("be_merge", rd, 32'hAA22_CC44);
`else
      check("be_ignored", rd, 32'h1122_3344);
`endif
      gap();

      // Reset in the first WAIT cycle drops the store
      old = ref_mem[4];
      dmem.req_valid = 1'b1;
      dmem.req_we    = 1'b1;
      dmem.req_addr  = 32'h10;
      dmem.req_wdata = 32'h55;
      dmem.req_be    = 4'hF;
      @(posedge clk);
      @(negedge clk);
      dmem.req_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("midrst_ready", 32'(dmem.req_ready), 32'd1);
      check("midrst_busy", 32'(dmem.busy), 32'd0);
      check("midrst_valid", 32'(dmem.resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (dmem.resp_valid) seen++;
      end
      check("midrst_no_resp", 32'(seen), 32'd0);
      do_op(1'b0, 32'h10, 32'h0, 4'hF, rd, t1);
      check("midrst_old", rd, old);
      gap();

      // Randomized traffic, sometimes back-to-back
      for (int n = 0; n < 250; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)       a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
         else if (r == 7) a = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
         else if (r == 8) a = 32'h100 | ($urandom & 32'h0000_0FFC);
         else             a = $urandom;
         do_op(1'($urandom), a, $urandom, ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom),
               rd, t1);
         if ($urandom_range(0, 2) != 0) begin
            gap();
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      gap();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
